// File: rtl/fir_mac_sequencer_if.sv
// Sample/coefficient/result bundle between the FIR sequencer, its sample source,
// the coefficient store and the DAC path.
interface fir_mac_sequencer_if #(
  parameter int NTaps      = 9,
  parameter int DataWidth  = 12,
  parameter int CoeffWidth = 12
);
  localparam int AddrWidth = $clog2(NTaps);

  logic                         start;
  logic signed [DataWidth-1:0]  x;
  logic                         symCoeffs;
  logic                         lock;
  logic [AddrWidth-1:0]         coeffAddr;
  logic signed [CoeffWidth-1:0] coeffData;
  logic                         busy;
  logic                         done;
  logic signed [DataWidth-1:0]  y;
  logic                         overrun;

  modport master (
    output start, x, symCoeffs, lock, coeffData,
    input  coeffAddr, busy, done, y, overrun
  );

  modport slave (
    input  start, x, symCoeffs, lock, coeffData,
    output coeffAddr, busy, done, y, overrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: circular sample delay line plus one MAC per clock,
// with optional symmetric pre-add and a lock bypass that passes samples straight through.
module fir_mac_sequencer #(
  parameter int NTaps      = 9,
  parameter int DataWidth  = 12,
  parameter int CoeffWidth = 12
) (
  input logic                clk,
  input logic                resetN,
  fir_mac_sequencer_if.slave bus
);
  localparam int AddrWidth = $clog2(NTaps);
  localparam int OpWidth   = DataWidth + 1;
  localparam int ProdWidth = OpWidth + CoeffWidth;
  localparam int AccWidth  = DataWidth + CoeffWidth + AddrWidth + 1;
  localparam logic [AddrWidth:0]          TapsWide  = (AddrWidth+1)'(NTaps);
  localparam logic [AddrWidth:0]          OneWide   = (AddrWidth+1)'(1);
  localparam logic [AddrWidth-1:0]        LastFull  = AddrWidth'(NTaps - 1);
  localparam logic [AddrWidth-1:0]        LastSym   = AddrWidth'((NTaps + 1) / 2 - 1);
  localparam logic [AddrWidth-1:0]        MidTap    = AddrWidth'((NTaps - 1) / 2);
  localparam bit                          OddTaps   = (NTaps % 2) == 1;
  localparam logic signed [AccWidth-1:0]  RoundBias = AccWidth'(2 ** (CoeffWidth - 2));
  localparam logic signed [AccWidth-1:0]  SatMax    = AccWidth'(2 ** (DataWidth - 1) - 1);
  localparam logic signed [AccWidth-1:0]  SatMin    = ~SatMax;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_ROUND, ST_DONE} state_t;

  state_t                       state_r, state_n;
  logic signed [DataWidth-1:0]  line_r [NTaps];
  logic [AddrWidth-1:0]         head_r;
  logic [AddrWidth-1:0]         k_r;
  logic signed [AccWidth-1:0]   acc_r;
  logic                         sym_r, lock_r;
  logic                         busy_r, done_r, overrun_r;
  logic signed [DataWidth-1:0]  y_r;

  logic [AddrWidth-1:0]         head_next_s, near_idx_s, far_idx_s;
  logic signed [DataWidth-1:0]  near_s, far_s;
  logic signed [OpWidth-1:0]    operand_s;
  logic signed [ProdWidth-1:0]  product_s;
  logic signed [AccWidth-1:0]   rounded_s;
  logic signed [DataWidth-1:0]  result_s;
  logic                         accept_s, last_k_s, fold_s;

  function automatic logic [AddrWidth-1:0] wrap_idx(input logic [AddrWidth:0] raw);
    if (raw >= TapsWide) return AddrWidth'(raw - TapsWide);
    else return raw[AddrWidth-1:0];
  endfunction

  function automatic logic signed [DataWidth-1:0] saturate(input logic signed [AccWidth-1:0] v);
    if (v > SatMax) return SatMax[DataWidth-1:0];
    else if (v < SatMin) return SatMin[DataWidth-1:0];
    else return v[DataWidth-1:0];
  endfunction

  // Tap addressing, symmetric pre-add, MAC product and final rounding.
  always_comb begin
    head_next_s = wrap_idx({1'b0, head_r} + OneWide);
    // age k sits k slots behind head; its mirror age NTaps-1-k sits k+1 slots ahead
    near_idx_s  = wrap_idx({1'b0, head_r} + TapsWide - {1'b0, k_r});
    far_idx_s   = wrap_idx({1'b0, head_r} + {1'b0, k_r} + OneWide);
    near_s      = line_r[near_idx_s];
    far_s       = line_r[far_idx_s];
    fold_s      = sym_r && !(OddTaps && (k_r == MidTap));
    if (fold_s) operand_s = OpWidth'(near_s) + OpWidth'(far_s);
    else operand_s = OpWidth'(near_s);
    product_s   = ProdWidth'(operand_s) * ProdWidth'(bus.coeffData);
    rounded_s   = (acc_r + RoundBias) >>> (CoeffWidth - 1);
    if (lock_r) result_s = line_r[head_r];
    else result_s = saturate(rounded_s);
    accept_s    = bus.start && (state_r == ST_IDLE);
    if (sym_r) last_k_s = (k_r == LastSym);
    else last_k_s = (k_r == LastFull);
  end

  // Next-state logic; a locked sample skips the MAC pass and goes straight to ROUND.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_n = bus.lock ? ST_ROUND : ST_MAC;
        else state_n = ST_IDLE;
      end
      ST_MAC: begin
        if (last_k_s) state_n = ST_ROUND;
        else state_n = ST_MAC;
      end
      ST_ROUND: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register, delay line, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r   <= ST_IDLE;
      for (int i = 0; i < NTaps; i++) line_r[i] <= '0;
      head_r    <= '0;
      k_r       <= '0;
      acc_r     <= '0;
      sym_r     <= 1'b0;
      lock_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      y_r       <= '0;
    end else begin
      state_r   <= state_n;
      busy_r    <= (state_n != ST_IDLE);
      done_r    <= (state_n == ST_DONE);
      overrun_r <= bus.start && (state_r != ST_IDLE);
      k_r       <= ((state_r == ST_MAC) && (state_n == ST_MAC)) ? k_r + AddrWidth'(1) : '0;
      if (accept_s) begin
        head_r              <= head_next_s;
        line_r[head_next_s] <= bus.x;
        sym_r               <= bus.symCoeffs;
        lock_r              <= bus.lock;
        acc_r               <= '0;
      end else if (state_r == ST_MAC) begin
        acc_r <= acc_r + AccWidth'(product_s);
      end
      if (state_r == ST_ROUND) y_r <= result_s;
    end
  end

  assign bus.coeffAddr = k_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.y         = y_r;
  assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: vector table plus hand-written corner sequences,
// results matched through a scoreboard queue of expected y and done latency.
module tb_fir_mac_sequencer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  fir_mac_sequencer_if #(.NTaps(9), .DataWidth(12), .CoeffWidth(12)) bus ();

  fir_mac_sequencer #(.NTaps(9), .DataWidth(12), .CoeffWidth(12)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  logic signed [11:0] coef_mem [0:15];
  assign bus.coeffData = coef_mem[bus.coeffAddr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic rst; int cset; int x; logic sym; logic lock; int exp_y; int exp_lat;
  } vec_t;
  typedef struct { int exp_y; int start_cyc; int exp_lat; } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input int cset, input int x, input logic sym,
                              input logic lock, input int exp_y, input int exp_lat);
    vec_t v;
    v = '{rst, cset, x, sym, lock, exp_y, exp_lat};
    vecs.push_back(v);
  endfunction

  task automatic set_coefs(input int cset);
    for (int i = 0; i < 16; i++) coef_mem[i] = 12'sd0;
    case (cset)
      0: coef_mem[0] = 12'sd1024;
      1: for (int i = 0; i < 9; i++) coef_mem[i] = 12'sd256;
      2: begin coef_mem[0] = 12'sd2047; coef_mem[1] = 12'sd2047; end
      3: coef_mem[1] = 12'sd1024;
      4: begin coef_mem[0] = 12'sd1024; coef_mem[1] = 12'sd1024; end
      default: coef_mem[0] = 12'sd0;
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetN = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_y"}, int'(bus.y), 0);
    check({tag, "_overrun"}, int'(bus.overrun), 0);
    check({tag, "_addr"}, int'(bus.coeffAddr), 0);
  endtask

  // One accepted sample: push expectation, then walk every cycle until idle again.
  task automatic run_sample(input int x, input logic sym, input logic lock,
                            input int exp_y, input int exp_lat, input string tag);
    int kmax;
    sb_t e;
    kmax = lock ? 0 : (sym ? 5 : 9);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x = x[11:0]; bus.symCoeffs = sym; bus.lock = lock;
    e = '{exp_y, cyc, exp_lat};
    sb_q.push_back(e);
    for (int i = 1; i <= exp_lat + 1; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "_addr"}, int'(bus.coeffAddr), (i <= kmax) ? i - 1 : 0);
      check({tag, "_busy"}, int'(bus.busy), (i <= exp_lat) ? 1 : 0);
    end
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (resetN && (bus.done === 1'b1)) begin
      if (sb_q.size() == 0) check("unexpected_done", sb_q.size(), 1);
      else begin
        e = sb_q.pop_front();
        check("y", int'(bus.y), e.exp_y);
        check("latency", cyc - e.start_cyc, e.exp_lat);
      end
    end
  end

  initial begin
    int t;
    bus.start = 1'b0; bus.x = '0; bus.symCoeffs = 1'b0; bus.lock = 1'b0;
    set_coefs(0);

    add(1, 0, 1000, 0, 0, 500, 11);
    add(0, 0, -7, 0, 0, -3, 11);
    add(0, 0, 3, 0, 0, 2, 11);
    add(0, 0, -2048, 0, 0, -1024, 11);
    add(0, 0, 2047, 0, 0, 1024, 11);
    add(0, 0, -300, 0, 1, -300, 2);
    add(0, 0, 1, 0, 0, 1, 11);
    add(0, 0, -1, 0, 0, 0, 11);
    for (int n = 1; n <= 9; n++) add(n == 1, 1, 800, 1, 0, 100 * n, 7);
    add(1, 2, 2047, 0, 0, 2046, 11);
    add(0, 2, 2047, 0, 0, 2047, 11);
    add(0, 2, -2048, 0, 0, -1, 11);
    add(0, 2, -2048, 0, 0, -2048, 11);

    do_reset();
    check_idle_outputs("reset");

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      set_coefs(vecs[i].cset);
      run_sample(vecs[i].x, vecs[i].sym, vecs[i].lock, vecs[i].exp_y, vecs[i].exp_lat,
                 $sformatf("vec%0d", i));
    end

    // Overrun: second start at t+3 dropped, pulse at t+4, sample never stored.
    do_reset();
    set_coefs(0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x = 12'sd400; bus.symCoeffs = 1'b0; bus.lock = 1'b0;
    t = cyc;
    sb_q.push_back('{200, t, 11});
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      bus.start = (i == 3);
      if (i == 3) bus.x = 12'sd999;
      check("ovr_pulse", int'(bus.overrun), (i == 4) ? 1 : 0);
    end
    check("ovr_sb_drained", sb_q.size(), 0);
    set_coefs(3);
    run_sample(5, 1'b0, 1'b0, 200, 11, "ovr_age1");

    // Lock bypass; lock dropped mid-computation and a start on the done cycle.
    do_reset();
    set_coefs(0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x = -12'sd300; bus.lock = 1'b1;
    t = cyc;
    sb_q.push_back('{-300, t, 2});
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      bus.lock = 1'b0;
      bus.start = (i == 2);
      if (i == 2) bus.x = 12'sd77;
      check("lock_addr", int'(bus.coeffAddr), 0);
      check("lock_overrun", int'(bus.overrun), (i == 3) ? 1 : 0);
    end
    bus.start = 1'b0;
    check("lock_sb_drained", sb_q.size(), 0);
    set_coefs(3);
    run_sample(1, 1'b0, 1'b0, -150, 11, "lock_age1");

    // Reset mid-MAC clears outputs and the delay line.
    do_reset();
    set_coefs(4);
    run_sample(1000, 1'b0, 1'b0, 500, 11, "pre_rst");
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x = 12'sd1000;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("midmac_busy", int'(bus.busy), 1);
    resetN = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midmac_rst");
    resetN = 1'b1;
    run_sample(1000, 1'b0, 1'b0, 500, 11, "post_rst");

    repeat (3) @(posedge clk);
    check("final_sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
